// File: rtl/video_timing_pkg.sv
// Shared raster timing constants (default VGA 640x480) and the frame-time direction type.
package video_timing_pkg;

  localparam int VGA_WIDTH  = 640;
  localparam int VGA_HEIGHT = 480;
  localparam int VGA_HFRONT = 16;
  localparam int VGA_HSYNC  = 96;
  localparam int VGA_HBACK  = 48;
  localparam int VGA_VFRONT = 10;
  localparam int VGA_VSYNC  = 2;
  localparam int VGA_VBACK  = 33;

  localparam int VGA_HTOTAL = VGA_WIDTH + VGA_HFRONT + VGA_HSYNC + VGA_HBACK;
  localparam int VGA_VTOTAL = VGA_HEIGHT + VGA_VFRONT + VGA_VSYNC + VGA_VBACK;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } time_dir_e;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter with sync pulse, blanking flag and last-position flag.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int RES   = VGA_WIDTH,
  parameter int FRONT = VGA_HFRONT,
  parameter int SYNC  = VGA_HSYNC,
  parameter int BACK  = VGA_HBACK,
  parameter bit POL   = 1'b0,
  localparam int TOTAL = RES + FRONT + SYNC + BACK,
  localparam int CW    = $clog2(TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_sync,
  output logic          o_blank,
  output logic          o_last
);

  logic [CW-1:0] r_count;
  logic [31:0]   w_pos;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (o_last) r_count <= '0;
      else        r_count <= r_count + CW'(1);
    end
  end

  // Compare in 32 bits so boundaries equal to 2^CW never truncate.
  assign w_pos   = 32'(r_count);
  assign o_last  = (w_pos == 32'(TOTAL - 1));
  assign o_blank = (w_pos >= 32'(RES));
  assign o_sync  = ((w_pos >= 32'(RES + FRONT)) && (w_pos < 32'(RES + FRONT + SYNC))) ? POL : ~POL;
  assign o_count = r_count;

endmodule

// File: rtl/video_frame_sequencer.sv
// Raster sequencer: timing, look-ahead shader coordinates and per-frame animation time.
// Define VIDEO_OUTPUT_REG_EN to register hsync_o/vsync_o/blank_o (one cycle behind the counters).
module video_frame_sequencer
  import video_timing_pkg::*;
#(
  parameter int WIDTH      = VGA_WIDTH,
  parameter int HEIGHT     = VGA_HEIGHT,
  parameter int HFRONT     = VGA_HFRONT,
  parameter int HSYNC      = VGA_HSYNC,
  parameter int HBACK      = VGA_HBACK,
  parameter int VFRONT     = VGA_VFRONT,
  parameter int VSYNC      = VGA_VSYNC,
  parameter int VBACK      = VGA_VBACK,
  parameter bit HPOL       = 1'b0,
  parameter bit VPOL       = 1'b0,
  parameter int SCALE_LOG2 = 3,
  parameter int LOOKAHEAD  = 8,
  parameter int TIME_W     = 8,
  localparam int HTOTAL = WIDTH + HFRONT + HSYNC + HBACK,
  localparam int VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK,
  localparam int HW     = $clog2(HTOTAL),
  localparam int VW     = $clog2(VTOTAL),
  localparam int XSW    = $clog2(WIDTH >> SCALE_LOG2),
  localparam int YSW    = $clog2(HEIGHT >> SCALE_LOG2)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pause_i,
  input  logic              bounce_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              blank_o,
  output logic              next_line_o,
  output logic              next_frame_o,
  output logic [HW-1:0]     h_cnt_o,
  output logic [VW-1:0]     v_cnt_o,
  output logic              active_o,
  output logic [XSW-1:0]    x_small_o,
  output logic [YSW-1:0]    y_small_o,
  output logic [TIME_W-1:0] time_o
);

  localparam logic [TIME_W-1:0] TIME_PEAK = {{(TIME_W-1){1'b1}}, 1'b0};
  localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);

  logic [HW-1:0] w_hCnt;
  logic [VW-1:0] w_vCnt;
  logic          w_hSync, w_vSync, w_hBlank, w_vBlank, w_hLast, w_vLast;
  logic          w_nextFrame;
  logic [31:0]   w_hSum, w_hLa, w_vLa;

  logic [TIME_W-1:0] r_time;
  time_dir_e         r_dir;

  video_axis_counter #(
    .RES(WIDTH), .FRONT(HFRONT), .SYNC(HSYNC), .BACK(HBACK), .POL(HPOL)
  ) u_hAxis (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(1'b1),
    .o_count(w_hCnt), .o_sync(w_hSync), .o_blank(w_hBlank), .o_last(w_hLast)
  );

  video_axis_counter #(
    .RES(HEIGHT), .FRONT(VFRONT), .SYNC(VSYNC), .BACK(VBACK), .POL(VPOL)
  ) u_vAxis (
    .i_clk(clk_i), .i_rst(rst_i), .i_en(w_hLast),
    .o_count(w_vCnt), .o_sync(w_vSync), .o_blank(w_vBlank), .o_last(w_vLast)
  );

  assign w_nextFrame = w_hLast & w_vLast;

  // Look-ahead may run past the end of the line into the next (possibly first) line.
  always_comb begin
    w_hSum = 32'(w_hCnt) + 32'(LOOKAHEAD);
    w_hLa  = w_hSum;
    w_vLa  = 32'(w_vCnt);
    if (w_hSum >= 32'(HTOTAL)) begin
      w_hLa = w_hSum - 32'(HTOTAL);
      w_vLa = w_vLast ? 32'd0 : 32'(w_vCnt) + 32'd1;
    end
  end

  assign active_o  = (w_hLa < 32'(WIDTH)) && (w_vLa < 32'(HEIGHT));
  assign x_small_o = XSW'(w_hLa >> SCALE_LOG2);
  assign y_small_o = YSW'(w_vLa >> SCALE_LOG2);

  // Bounce turns around one step early so the peak and zero are each shown once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_time <= '0;
      r_dir  <= DIR_UP;
    end else if (w_nextFrame && !pause_i) begin
      if (!bounce_i) begin
        r_time <= r_time + TIME_ONE;
        r_dir  <= DIR_UP;
      end else if (r_dir == DIR_UP) begin
        r_time <= r_time + TIME_ONE;
        if (r_time == TIME_PEAK) r_dir <= DIR_DOWN;
      end else begin
        r_time <= r_time - TIME_ONE;
        if (r_time == TIME_ONE) r_dir <= DIR_UP;
      end
    end
  end

`ifdef VIDEO_OUTPUT_REG_EN
  logic r_hsync, r_vsync, r_blank;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hsync <= ~HPOL;
      r_vsync <= ~VPOL;
      r_blank <= 1'b0;
    end else begin
      r_hsync <= w_hSync;
      r_vsync <= w_vSync;
      r_blank <= w_hBlank | w_vBlank;
    end
  end

  assign hsync_o = r_hsync;
  assign vsync_o = r_vsync;
  assign blank_o = r_blank;
`else
  assign hsync_o = w_hSync;
  assign vsync_o = w_vSync;
  assign blank_o = w_hBlank | w_vBlank;
`endif

  assign next_line_o  = w_hLast;
  assign next_frame_o = w_nextFrame;
  assign h_cnt_o      = w_hCnt;
  assign v_cnt_o      = w_vCnt;
  assign time_o       = r_time;

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Bench: a tiny-raster instance (time behaviour, reset) and a default VGA instance (timing literals),
// both checked every cycle against a cycle-count-based model.
module tb_video_frame_sequencer;

  localparam int SW = 6, SH = 4, SHF = 1, SHS = 1, SHB = 1, SVF = 1, SVS = 1, SVB = 1;
  localparam int SS = 1, SLA = 3;
  localparam int SHT = SW + SHF + SHS + SHB;
  localparam int SVT = SH + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;
  localparam int SHW = $clog2(SHT), SVW = $clog2(SVT);
  localparam int SXW = $clog2(SW >> SS), SYW = $clog2(SH >> SS);
  localparam int TMAX = 255;
`ifdef VIDEO_OUTPUT_REG_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  typedef struct packed {
    int w, h, hf, hs, hb, vf, vs, vb, hp, vp, s, la;
  } cfg_t;

  typedef struct packed {
    logic hsync, vsync, blank, nline, nframe, active;
    logic [31:0] h, v, x, y;
  } exp_t;

  localparam cfg_t CFG_S = '{SW, SH, SHF, SHS, SHB, SVF, SVS, SVB, 1, 0, SS, SLA};
  localparam cfg_t CFG_V = '{640, 480, 16, 96, 48, 10, 2, 33, 0, 0, 3, 8};

  logic clk, rst, rstVga, pause, bounce;

  logic sHsync, sVsync, sBlank, sNline, sNframe, sActive;
  logic [SHW-1:0] sH;
  logic [SVW-1:0] sV;
  logic [SXW-1:0] sX;
  logic [SYW-1:0] sY;
  logic [7:0] sTime;

  logic vHsync, vVsync, vBlank, vNline, vNframe, vActive;
  logic [9:0] vH, vV;
  logic [6:0] vX;
  logic [5:0] vY;
  logic [7:0] vTime;

  int checks = 0;
  int errors = 0;
  int cycS, cycV, mTime;
  bit mDown;

  video_frame_sequencer #(
    .WIDTH(SW), .HEIGHT(SH), .HFRONT(SHF), .HSYNC(SHS), .HBACK(SHB),
    .VFRONT(SVF), .VSYNC(SVS), .VBACK(SVB), .HPOL(1'b1), .VPOL(1'b0),
    .SCALE_LOG2(SS), .LOOKAHEAD(SLA), .TIME_W(8)
  ) dutSmall (
    .clk_i(clk), .rst_i(rst), .pause_i(pause), .bounce_i(bounce),
    .hsync_o(sHsync), .vsync_o(sVsync), .blank_o(sBlank),
    .next_line_o(sNline), .next_frame_o(sNframe),
    .h_cnt_o(sH), .v_cnt_o(sV), .active_o(sActive),
    .x_small_o(sX), .y_small_o(sY), .time_o(sTime)
  );

  video_frame_sequencer dutVga (
    .clk_i(clk), .rst_i(rstVga), .pause_i(pause), .bounce_i(bounce),
    .hsync_o(vHsync), .vsync_o(vVsync), .blank_o(vBlank),
    .next_line_o(vNline), .next_frame_o(vNframe),
    .h_cnt_o(vH), .v_cnt_o(vV), .active_o(vActive),
    .x_small_o(vX), .y_small_o(vY), .time_o(vTime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs derived purely from the number of cycles since reset release.
  function automatic exp_t modelAt(cfg_t c, int cyc);
    exp_t e;
    int ht, vt, h, v, la, hla, vla;
    ht = c.w + c.hf + c.hs + c.hb;
    vt = c.h + c.vf + c.vs + c.vb;
    h = cyc % ht;
    v = (cyc / ht) % vt;
    la = cyc + c.la;
    hla = la % ht;
    vla = (la / ht) % vt;
    e.h = h;
    e.v = v;
    e.hsync = (h >= c.w + c.hf && h < c.w + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
    e.vsync = (v >= c.h + c.vf && v < c.h + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
    e.blank = (h >= c.w) || (v >= c.h);
    e.nline = (h == ht - 1);
    e.nframe = (h == ht - 1) && (v == vt - 1);
    e.active = (hla < c.w) && (vla < c.h);
    e.x = hla >> c.s;
    e.y = vla >> c.s;
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      if (errors >= 40) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic p, input logic b);
    rst = r;
    rstVga = rv;
    pause = p;
    bounce = b;
  endtask

  task automatic waitSmall(input int target);
    int guard = 0;
    while (cycS < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("waitSmall.reached", cycS, target);
  endtask

  task automatic waitVga(input int target);
    int guard = 0;
    while (cycV < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("waitVga.reached", cycV, target);
  endtask

  // Frame-time model: one step per completed frame, bouncing between 0 and TMAX.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cycS <= 0;
      mTime <= 0;
      mDown <= 1'b0;
    end else begin
      if (((cycS + 1) % SFRAME == 0) && !pause) begin
        if (!bounce) begin
          mTime <= (mTime + 1) % (TMAX + 1);
          mDown <= 1'b0;
        end else if (!mDown) begin
          mTime <= (mTime + 1) % (TMAX + 1);
          if (mTime + 1 == TMAX) mDown <= 1'b1;
        end else begin
          mTime <= mTime - 1;
          if (mTime - 1 == 0) mDown <= 1'b0;
        end
      end
      cycS <= cycS + 1;
    end
  end

  always @(posedge clk or posedge rstVga) begin
    if (rstVga) cycV <= 0;
    else        cycV <= cycV + 1;
  end

  always @(negedge clk) begin
    exp_t e, ep;
    e  = modelAt(CFG_S, cycS);
    ep = modelAt(CFG_S, (cycS > LAG) ? cycS - LAG : 0);
    checkOutput("s.h_cnt", sH, e.h);
    checkOutput("s.v_cnt", sV, e.v);
    checkOutput("s.hsync", sHsync, ep.hsync);
    checkOutput("s.vsync", sVsync, ep.vsync);
    checkOutput("s.blank", sBlank, ep.blank);
    checkOutput("s.next_line", sNline, e.nline);
    checkOutput("s.next_frame", sNframe, e.nframe);
    checkOutput("s.active", sActive, e.active);
    if (e.active) begin
      checkOutput("s.x_small", sX, e.x);
      checkOutput("s.y_small", sY, e.y);
    end
    checkOutput("s.time", sTime, mTime);

    e  = modelAt(CFG_V, cycV);
    ep = modelAt(CFG_V, (cycV > LAG) ? cycV - LAG : 0);
    checkOutput("v.h_cnt", vH, e.h);
    checkOutput("v.v_cnt", vV, e.v);
    checkOutput("v.hsync", vHsync, ep.hsync);
    checkOutput("v.vsync", vVsync, ep.vsync);
    checkOutput("v.blank", vBlank, ep.blank);
    checkOutput("v.next_line", vNline, e.nline);
    checkOutput("v.next_frame", vNframe, e.nframe);
    checkOutput("v.active", vActive, e.active);
    if (e.active) begin
      checkOutput("v.x_small", vX, e.x);
      checkOutput("v.y_small", vY, e.y);
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int t;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("rst.s.h", sH, 0);
    checkOutput("rst.s.v", sV, 0);
    checkOutput("rst.s.time", sTime, 0);
    checkOutput("rst.s.hsync", sHsync, 0);
    checkOutput("rst.s.vsync", sVsync, 1);
    checkOutput("rst.s.blank", sBlank, 0);
    checkOutput("rst.s.next_line", sNline, 0);
    checkOutput("rst.s.next_frame", sNframe, 0);
    checkOutput("rst.s.active", sActive, 1);
    checkOutput("rst.s.x_small", sX, 1);
    checkOutput("rst.v.hsync", vHsync, 1);
    checkOutput("rst.v.active", vActive, 1);
    checkOutput("rst.v.x_small", vX, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] VGA line timing and look-ahead");
    waitVga(632);
    checkOutput("vga.h632.h_cnt", vH, 632);
    checkOutput("vga.h632.active", vActive, 0);
    waitVga(639 + LAG);
    checkOutput("vga.blank_before", vBlank, 0);
    waitVga(640 + LAG);
    checkOutput("vga.blank_rise", vBlank, 1);
    waitVga(655 + LAG);
    checkOutput("vga.hsync_before", vHsync, 1);
    waitVga(656 + LAG);
    checkOutput("vga.hsync_start", vHsync, 0);
    waitVga(751 + LAG);
    checkOutput("vga.hsync_last", vHsync, 0);
    waitVga(752 + LAG);
    checkOutput("vga.hsync_end", vHsync, 1);
    waitVga(792);
    checkOutput("vga.h792.active", vActive, 1);
    checkOutput("vga.h792.x_small", vX, 0);
    checkOutput("vga.h792.y_small", vY, 0);
    waitVga(799);
    checkOutput("vga.h799.next_line", vNline, 1);
    checkOutput("vga.h799.next_frame", vNframe, 0);
    waitVga(17 * 800 + 87);
    checkOutput("vga.h87v17.v_cnt", vV, 17);
    checkOutput("vga.h87v17.x_small", vX, 11);
    checkOutput("vga.h87v17.y_small", vY, 2);

    $display("[TB] asynchronous reset mid-line");
    t = (cycS / SFRAME + 1) * SFRAME + 2 * SHT + 7;
    waitSmall(t);
    checkOutput("pre_rst.h", sH, 7);
    checkOutput("pre_rst.v", sV, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst.h", sH, 0);
    checkOutput("async_rst.v", sV, 0);
    checkOutput("async_rst.time", sTime, 0);
    checkOutput("async_rst.hsync", sHsync, 0);
    checkOutput("async_rst.blank", sBlank, 0);
    checkOutput("async_rst.active", sActive, 1);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] look-ahead wrap on the small raster");
    waitSmall(3 * SHT + 6);
    checkOutput("s.last_visible_line.active", sActive, 0);
    waitSmall(6 * SHT + 6);
    checkOutput("s.frame_wrap.active", sActive, 1);
    checkOutput("s.frame_wrap.y_small", sY, 0);
    waitSmall(SFRAME - 1);
    checkOutput("s.frame_end.next_frame", sNframe, 1);

    $display("[TB] bounce mode");
    waitSmall(255 * SFRAME);
    checkOutput("bounce.f255", sTime, 255);
    waitSmall(256 * SFRAME);
    checkOutput("bounce.f256", sTime, 254);
    waitSmall(510 * SFRAME);
    checkOutput("bounce.f510", sTime, 0);
    waitSmall(511 * SFRAME);
    checkOutput("bounce.f511", sTime, 1);

    $display("[TB] wrap mode and pause");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitSmall(765 * SFRAME);
    checkOutput("wrap.peak", sTime, 255);
    waitSmall(766 * SFRAME);
    checkOutput("wrap.rollover", sTime, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitSmall(769 * SFRAME);
    checkOutput("pause.held", sTime, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitSmall(770 * SFRAME);
    checkOutput("pause.resumed", sTime, 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
